// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core; this slice carries the SQI
// memory controller definitions.
package idli_pkg;

    typedef enum logic {
        SQI_MEM_LO = 1'b0,
        SQI_MEM_HI = 1'b1
    } sqi_mem_t;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [2:0] {
        SQI_IDLE  = 3'd0,
        SQI_CMD   = 3'd1,
        SQI_ADDR  = 3'd2,
        SQI_DUMMY = 3'd3,
        SQI_RDATA = 3'd4,
        SQI_WDATA = 3'd5,
        SQI_GAP   = 3'd6
    } sqi_state_t;

    localparam logic [2:0] SQI_CMD_CYC   = 3'd2;
    localparam logic [2:0] SQI_ADDR_CYC  = 3'd6;
    localparam logic [2:0] SQI_DUMMY_CYC = 3'd2;

    localparam logic [7:0] SQI_CMD_RD = 8'h03;
    localparam logic [7:0] SQI_CMD_WR = 8'h02;

endpackage

// File: rtl/idli_sqi_ctrl.sv
// Drives two nibble-wide SQI memories in lockstep so that together they look
// like one 16-bit word-addressed memory with sequential streaming.
module idli_sqi_ctrl
    import idli_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_vld,
    output logic                  o_req_rdy,
    input  logic                  i_req_wr,
    input  logic [15:0]           i_req_addr,
    input  logic                  i_stop,
    output logic                  o_rd_vld,
    output logic [15:0]           o_rd_word,
    input  logic                  i_wr_vld,
    input  logic [15:0]           i_wr_word,
    output logic                  o_wr_rdy,
    output logic                  o_sqi_cs,
    output logic                  o_sqi_oe,
    output sqi_data_t [1:0]       o_sqi_dout,
    input  sqi_data_t [1:0]       i_sqi_din
);

    sqi_state_t  state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [15:0] addr_r;
    logic        wr_r;
    logic [7:0]  rd_even_r;
    logic [7:0]  wr_lo_r;
    logic        rd_vld_r;
    logic [15:0] rd_word_r;
    logic [7:0]  cmd_s;
    logic        wr_take_s;
    sqi_data_t   dout_lo_s, dout_hi_s;

    assign cmd_s     = wr_r ? SQI_CMD_WR : SQI_CMD_RD;
    // A stop at a word boundary must not consume a word that can never finish.
    assign wr_take_s = i_wr_vld && !i_stop;

    // Next-state selection; the cycle counter restarts on every state change.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + 3'd1;
        case (state_r)
            SQI_IDLE: begin
                if (i_req_vld) state_s = SQI_CMD;
                else           state_s = SQI_IDLE;
            end
            SQI_CMD: begin
                if (i_stop)                              state_s = SQI_GAP;
                else if (cnt_r == SQI_CMD_CYC - 3'd1)    state_s = SQI_ADDR;
                else                                     state_s = SQI_CMD;
            end
            SQI_ADDR: begin
                if (i_stop)                              state_s = SQI_GAP;
                else if (cnt_r != SQI_ADDR_CYC - 3'd1)   state_s = SQI_ADDR;
                else if (wr_r)                           state_s = SQI_WDATA;
                else                                     state_s = SQI_DUMMY;
            end
            SQI_DUMMY: begin
                if (i_stop)                              state_s = SQI_GAP;
                else if (cnt_r == SQI_DUMMY_CYC - 3'd1)  state_s = SQI_RDATA;
                else                                     state_s = SQI_DUMMY;
            end
            SQI_RDATA: begin
                if (i_stop) state_s = SQI_GAP;
                else        state_s = SQI_RDATA;
            end
            SQI_WDATA: begin
                if (i_stop)                         state_s = SQI_GAP;
                else if (!cnt_r[0] && !i_wr_vld)    state_s = SQI_GAP;
                else                                state_s = SQI_WDATA;
            end
            SQI_GAP:  state_s = SQI_IDLE;
            default:  state_s = SQI_IDLE;
        endcase
        if (state_s != state_r) cnt_s = 3'd0;
        else                    cnt_s = cnt_r + 3'd1;
    end

    // State and phase counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= SQI_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request capture and the low byte of the word being written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_r  <= 16'h0000;
            wr_r    <= 1'b0;
            wr_lo_r <= 8'h00;
        end else begin
            if (state_r == SQI_IDLE && i_req_vld) begin
                addr_r <= i_req_addr;
                wr_r   <= i_req_wr;
            end
            if (state_r == SQI_WDATA && !cnt_r[0] && wr_take_s) begin
                wr_lo_r <= i_wr_word[7:0];
            end
        end
    end

    // Read nibble assembly: even cycle carries bits 15:8, odd cycle bits 7:0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_even_r <= 8'h00;
            rd_vld_r  <= 1'b0;
            rd_word_r <= 16'h0000;
        end else begin
            rd_vld_r <= 1'b0;
            if (state_r == SQI_RDATA) begin
                if (!cnt_r[0]) begin
                    rd_even_r <= {i_sqi_din[SQI_MEM_HI], i_sqi_din[SQI_MEM_LO]};
                end else begin
                    rd_word_r <= {rd_even_r, i_sqi_din[SQI_MEM_HI], i_sqi_din[SQI_MEM_LO]};
                    rd_vld_r  <= 1'b1;
                end
            end
        end
    end

    // Pin-level decode of the current phase.
    always_comb begin
        o_req_rdy = 1'b0;
        o_sqi_cs  = 1'b0;
        o_sqi_oe  = 1'b0;
        o_wr_rdy  = 1'b0;
        dout_lo_s = 4'h0;
        dout_hi_s = 4'h0;
        case (state_r)
            SQI_IDLE: o_req_rdy = 1'b1;
            SQI_CMD: begin
                o_sqi_cs = 1'b1;
                o_sqi_oe = 1'b1;
                if (cnt_r[0]) dout_lo_s = cmd_s[3:0];
                else          dout_lo_s = cmd_s[7:4];
                dout_hi_s = dout_lo_s;
            end
            SQI_ADDR: begin
                o_sqi_cs = 1'b1;
                o_sqi_oe = 1'b1;
                // Byte address is {8'h00, addr}: the first two nibbles are zero.
                case (cnt_r)
                    3'd2:    dout_lo_s = addr_r[15:12];
                    3'd3:    dout_lo_s = addr_r[11:8];
                    3'd4:    dout_lo_s = addr_r[7:4];
                    3'd5:    dout_lo_s = addr_r[3:0];
                    default: dout_lo_s = 4'h0;
                endcase
                dout_hi_s = dout_lo_s;
            end
            SQI_DUMMY: o_sqi_cs = 1'b1;
            SQI_RDATA: o_sqi_cs = 1'b1;
            SQI_WDATA: begin
                o_sqi_cs = 1'b1;
                o_sqi_oe = 1'b1;
                if (cnt_r[0]) begin
                    dout_lo_s = wr_lo_r[3:0];
                    dout_hi_s = wr_lo_r[7:4];
                end else if (wr_take_s) begin
                    o_wr_rdy  = 1'b1;
                    dout_lo_s = i_wr_word[11:8];
                    dout_hi_s = i_wr_word[15:12];
                end else begin
                    dout_lo_s = 4'h0;
                    dout_hi_s = 4'h0;
                end
            end
            SQI_GAP: o_sqi_cs = 1'b0;
            default: o_sqi_cs = 1'b0;
        endcase
    end

    assign o_sqi_dout = {dout_hi_s, dout_lo_s};
    assign o_rd_vld   = rd_vld_r;
    assign o_rd_word  = rd_word_r;

endmodule

// File: doc/idli_sqi_ctrl.md
Name: idli_sqi_ctrl

Overview:
- Sequences the two SQI memories (SQI_MEM_LO holds the low nibble of each byte, SQI_MEM_HI holds the high nibble) so they behave as one 16-bit word-addressed memory.
- Issues command, address and dummy phases to both devices in lockstep, then streams sequential words for reads or writes.
- Sits between the fetch/load-store logic and the board SQI pins.
- Each memory holds one byte per 16-bit word.
  - LO device byte = {w[11:8], w[3:0]}.
  - HI device byte = {w[15:12], w[7:4]}.

Parameters:
- CMD_RD, 8'h03, SQI read opcode.
- CMD_WR, 8'h02, SQI write opcode.
- DUMMY_CYC, 2, nibble cycles between the end of the address and the first read data.

Ports:
- i_clk  in  1  core clock; SCK is i_clk, gated by o_sqi_cs.
- i_rst  in  1  synchronous active-high reset.
- i_req_vld  in  1  start a transaction.
- o_req_rdy  out  1  controller can accept a request.
- i_req_wr  in  1  1 = write transaction, 0 = read.
- i_req_addr  in  16  starting word address.
- i_stop  in  1  end the current transaction (e.g. PC redirect).
- o_rd_vld  out  1  o_rd_word valid this cycle.
- o_rd_word  out  16  assembled read word.
- i_wr_vld  in  1  write word available.
- i_wr_word  in  16  write data.
- o_wr_rdy  out  1  write word consumed this cycle.
- o_sqi_cs  out  1  chip select, active-high internally, shared by both devices.
- o_sqi_oe  out  1  controller drives the SQI data pins.
- o_sqi_dout  out  2x sqi_data_t  per-memory output nibble, index sqi_mem_t.
- i_sqi_din  in  2x sqi_data_t  per-memory input nibble.

Behaviour:
- Reset values: state IDLE; all outputs 0 except o_req_rdy = 1. A reset mid-transaction aborts it immediately; CS is low the following cycle.
- Request handshake: a request is accepted when i_req_vld && o_req_rdy. o_req_rdy = 1 only in IDLE.
  - On acceptance, latch addr and wr, then go to CMD next cycle.
- States:
  - IDLE -> CMD: on accept.
  - CMD: 2 cycles, opcode MSB nibble first, same nibble on both devices, oe = 1.
  - ADDR: 6 cycles, 24-bit byte address {8'h00, addr}, MSB nibble first.
  - ADDR -> DUMMY when reading; ADDR -> WDATA when writing.
  - DUMMY: DUMMY_CYC cycles, oe = 0.
  - RDATA: continuous.
  - WDATA: continuous.
  - GAP: exactly 1 cycle, cs = 0, then IDLE.
- Cycle counter: 3 bits, reloaded on every state entry.
- o_sqi_cs is 1 in CMD, ADDR, DUMMY, RDATA and WDATA; 0 in IDLE and GAP.
- RDATA:
  - Even cycle: capture LO -> w[11:8], HI -> w[15:12].
  - Odd cycle: LO -> w[3:0], HI -> w[7:4].
  - o_rd_vld pulses on the cycle after the odd nibble is sampled, with the full word.
  - Then repeat; the device auto-increments, so each new word is the next address.
  - First o_rd_vld = acceptance cycle + 1 + 2 + 6 + DUMMY_CYC + 2, i.e. 13 cycles after acceptance with defaults.
- WDATA:
  - At each word boundary (first WDATA cycle and every second cycle after), if i_wr_vld = 1:
    - Pulse o_wr_rdy and latch the word.
    - Drive LO = w[11:8], HI = w[15:12] that cycle, then w[3:0] / w[7:4] the next cycle.
  - If i_wr_vld = 0 at a boundary, go to GAP; no partial byte is ever written.
- i_stop:
  - In any state other than IDLE or GAP, the next state is GAP.
  - A word whose odd nibble is sampled in the i_stop cycle is still delivered on o_rd_vld.
  - i_stop in IDLE is ignored.
  - i_stop and i_req_vld in the same IDLE cycle: request accepted.
- Address is not tracked by the controller. Wrap from 16'hFFFF goes to device byte 24'h010000 per device behaviour; software must not stream across 16'hFFFF.
- o_sqi_oe = 1 only in CMD, ADDR and WDATA.

Decomposition:
- Add to idli_pkg:
  - sqi_state_t enum (IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP).
  - localparams SQI_CMD_CYC = 2 and SQI_ADDR_CYC = 6.
  - SQI_CMD_RD / SQI_CMD_WR opcodes.
- Reuse sqi_mem_t and sqi_data_t for indexing and nibbles.
- No sub-module needed. Nibble assembly and disassembly is a small shift register kept inline.

Test Plan:
- Reset then read: req addr 16'h1234 rd; LO returns 4'hA,4'hB and HI returns 4'hC,4'hD -> CMD nibbles 0,3; ADDR nibbles 0,0,1,2,3,4; o_rd_word = 16'hCADB with o_rd_vld 13 cycles after accept.
- Streaming read: hold 3 words without i_stop -> o_rd_vld every 2 cycles with words in order; i_stop -> cs low next cycle, 1 GAP cycle, o_req_rdy back 2 cycles after i_stop.
- Write: req addr 16'h0010 wr with i_wr_word 16'hBEEF -> CMD 0,2; no dummy; LO sees E,F and HI sees B,E; o_wr_rdy pulses once; i_wr_vld low at next boundary -> GAP.
- i_stop during ADDR cycle 3 -> no o_rd_vld ever, cs low next cycle, IDLE after GAP.
- i_rst asserted in RDATA -> cs = 0, oe = 0, o_rd_vld = 0 next cycle, o_req_rdy = 1; a following request runs normally.
- Request held during GAP -> not accepted until IDLE (o_req_rdy = 0 in GAP).
